ber_checker: RTL and testbench
==============================

# ber_checker

Bit-error-rate checker for the QPSK PRBS link: the receiving end of the PRBS generator. It regenerates the same PRBS9 sequence locally, searches for the symbol delay between its reference and the demodulated bit stream from `rx`, and locks onto it. Once locked, it counts the bits compared and the bit errors. It sits after `rx` and is driven by the same symbol strobe that advances the transmit-side PRBS.

## Interface
- `SEED`, 9'h1AA: LFSR load value at reset; must match the generator's seed.
- `DELAY_MAX`, 32: number of candidate delays searched (0..DELAY_MAX-1); also the depth of the reference history.
- `WINDOW`, 64: valid strobes per evaluation window.
- `LOCK_THRESH`, 4: maximum window errors allowed to declare lock.
- `UNLOCK_THRESH`, 16: window errors above this value drop lock.
- `COUNT_W`, 32: width of `bit_count` and `err_count`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `valid_in`, in, 1: one-cycle strobe marking a new received bit (one per symbol).
- `rx_in`, in, 1: received bit from `rx`, sampled when `valid_in`=1.
- `clr`, in, 1: synchronous clear of `bit_count` and `err_count`.
- `locked`, out, 1: checker is aligned.
- `delay_out`, out, $clog2(DELAY_MAX): current candidate or locked delay, in strobes.
- `bit_count`, out, COUNT_W: bits compared since lock or `clr`.
- `err_count`, out, COUNT_W: errors since lock or `clr`.

## Operation
- **Reference LFSR:** PRBS9, x^9+x^5+1, Fibonacci form, loaded with `SEED` at reset.
  - On each `valid_in`: `p` = lfsr[8]; then lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]}.
- **History:** hist (DELAY_MAX bits, reset 0).
  - On `valid_in`: hist <= {hist[DELAY_MAX-2:0], p}.
  - The compared reference bit is hist_next[delay], where hist_next[0] = `p` of the same strobe.
  - Error e = `rx_in` ^ hist_next[delay].
- **Window:** win_cnt counts strobes 0..WINDOW-1; win_err accumulates e.
  - The window ends on the strobe where win_cnt = WINDOW-1.
  - Total for that window = win_err + e. Then win_cnt and win_err restart at 0.
- **FSM SEARCH** (reset state):
  - At window end with total <= LOCK_THRESH: go to LOCKED, set `locked`=1, clear `bit_count` and `err_count` to 0.
  - Otherwise advance delay by 1, wrapping DELAY_MAX-1 -> 0.
  - Counters are frozen while in SEARCH.
- **FSM LOCKED:**
  - Each strobe: `bit_count` += 1, `err_count` += e.
  - Each counter saturates independently at 2^COUNT_W-1.
  - At window end with total > UNLOCK_THRESH: go to SEARCH, `locked`=0, keep the same delay (it is re-tested first), keep the counter values.
- **`clr`:** zeroes both counters in any state. On a cycle with both `clr` and `valid_in`, `clr` wins and the counters read 0, not 1. `clr` does not affect the FSM, window, LFSR or delay.
- Strobes arriving during the first DELAY_MAX strobes after reset compare against zero-filled history. This is allowed; such windows simply fail.

## Timing
- **Reset values:** `locked`=0, `delay_out`=0, `bit_count`=0, `err_count`=0, state SEARCH, lfsr=SEED, hist=0, win_cnt=0, win_err=0.
- **Latency:** all outputs are registered and update on the rising edge that samples `valid_in`=1, visible the cycle after the strobe.
- `locked` and `delay_out` change only on window-end edges.
- Idle cycles (`valid_in`=0) hold all state; strobes may come at any spacing, including back-to-back.
- **Reset mid-operation:** immediate return to the reset values. The next strobe uses `p` = SEED[8].
- **Time to lock:** a stream delayed by d < DELAY_MAX locks at the end of window d+1, i.e. (d+1)*WINDOW strobes after reset, assuming the first windows fail.

## Test plan
- **Aligned lock:** generator (SEED 9'h1AA) feeding `rx_in` delayed by 5 strobes, strobe every 4 clk -> `delay_out` steps 0..5, `locked`=1 after strobe 384, `err_count`=0, `bit_count` increments by 1 per strobe.
- **Single-bit errors:** after lock, flip one `rx_in` bit every 100 strobes for 1000 strobes -> `err_count`=10, `bit_count`=1000, `locked` stays 1.
- **Loss of lock:** after lock, invert `rx_in` continuously -> `err_count` +1 per strobe, `locked`=0 at the first window end, `delay_out` unchanged, search resumes at the same delay.
- **Delay bounds:**
  - delay 31 -> locks after 32 windows with `delay_out`=31.
  - delay 40 -> never locks, `delay_out` wraps 31 -> 0.
- **clr and reset:**
  - `clr` with `valid_in` while locked -> both counts 0 the next cycle.
  - `rst` low mid-LOCKED -> all outputs 0 asynchronously, relock proceeds as in the aligned-lock scenario.
- **Saturation:** COUNT_W=4 with an all-error stream forced locked -> `bit_count` and `err_count` stop at 15.

Source files
------------

// File: rtl/ber_checker.sv
// rtl/ber_checker.sv - PRBS9 bit-error-rate checker with delay search, lock and error counters
module ber_checker #(
  parameter logic [8:0] SEED          = 9'h1AA,
  parameter int         DELAY_MAX     = 32,
  parameter int         WINDOW        = 64,
  parameter int         LOCK_THRESH   = 4,
  parameter int         UNLOCK_THRESH = 16,
  parameter int         COUNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic                         rx_in,
  input  logic                         clr,
  output logic                         locked,
  output logic [$clog2(DELAY_MAX)-1:0] delay_out,
  output logic [COUNT_W-1:0]           bit_count,
  output logic [COUNT_W-1:0]           err_count
);

  localparam int DW = $clog2(DELAY_MAX);
  localparam int CW = $clog2(WINDOW);
  localparam int EW = $clog2(WINDOW + 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [8:0]           lfsr_q, lfsr_d;
  // Only DELAY_MAX-1 past bits are stored; the newest reference bit is p itself.
  logic [DELAY_MAX-2:0] hist_q, hist_d;
  logic [DW-1:0]        delay_q, delay_d;
  logic [CW-1:0]        win_cnt_q, win_cnt_d;
  logic [EW-1:0]        win_err_q, win_err_d;
  logic [COUNT_W-1:0]   bit_count_q, bit_count_d;
  logic [COUNT_W-1:0]   err_count_q, err_count_d;

  logic                 p;
  logic [DELAY_MAX-1:0] hist_next;
  logic                 e;
  logic                 win_end;
  logic [EW-1:0]        total;

  // Reference bit for this strobe, its error against rx, and the window-end decode
  always_comb begin
    p         = lfsr_q[8];
    hist_next = {hist_q, p};
    e         = rx_in ^ hist_next[delay_q];
    win_end   = (win_cnt_q == CW'(WINDOW - 1));
    total     = win_err_q + EW'(e);
  end

  // Next-state logic: LFSR/history advance, window accounting, search/lock decisions, counters
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    hist_d      = hist_q;
    delay_d     = delay_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;
    if (valid_in) begin
      lfsr_d = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
      hist_d = hist_next[DELAY_MAX-2:0];
      if (state_q == LOCKED) begin
        if (bit_count_q != '1) bit_count_d = bit_count_q + COUNT_W'(1);
        if (e && (err_count_q != '1)) err_count_d = err_count_q + COUNT_W'(1);
      end
      if (win_end) begin
        win_cnt_d = '0;
        win_err_d = '0;
        if (state_q == SEARCH) begin
          if (total <= EW'(LOCK_THRESH)) begin
            state_d     = LOCKED;
            bit_count_d = '0;
            err_count_d = '0;
          end else if (delay_q == DW'(DELAY_MAX - 1)) begin
            delay_d = '0;
          end else begin
            delay_d = delay_q + DW'(1);
          end
        end else if (total > EW'(UNLOCK_THRESH)) begin
          // Delay is kept so the same alignment is re-tested first.
          state_d = SEARCH;
        end
      end else begin
        win_cnt_d = win_cnt_q + CW'(1);
        win_err_d = total;
      end
    end
    // Clear overrides any increment or lock-time reload in the same cycle.
    if (clr) begin
      bit_count_d = '0;
      err_count_d = '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEARCH;
      lfsr_q      <= SEED;
      hist_q      <= '0;
      delay_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      hist_q      <= hist_d;
      delay_q     <= delay_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign delay_out = delay_q;
  assign bit_count = bit_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ber_checker.sv
// tb/tb_ber_checker.sv - self-checking bench for ber_checker against a PRBS reference model
module tb_ber_checker;

  localparam int WIN = 64;
  localparam int DMAX = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        rx_in = 1'b0;
  logic        clr = 1'b0;
  logic        locked;
  logic [4:0]  delay_out;
  logic [31:0] bit_count;
  logic [31:0] err_count;
  logic        locked4;
  logic [4:0]  delay4;
  logic [3:0]  bit4;
  logic [3:0]  err4;

  int n_chk = 0;
  int n_fail = 0;

  bit gen [0:4095];
  int tx_k = 0;
  int txd = 0;

  // model state
  int     k = 0;
  bit     m_locked = 1'b0;
  int     m_delay = 0;
  int     m_wc = 0;
  int     m_we = 0;
  longint m_bit = 0, m_err = 0, m_bit4 = 0, m_err4 = 0;
  int     m_e;

  ber_checker dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .rx_in(rx_in), .clr(clr),
    .locked(locked), .delay_out(delay_out), .bit_count(bit_count), .err_count(err_count)
  );

  ber_checker #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .rx_in(rx_in), .clr(clr),
    .locked(locked4), .delay_out(delay4), .bit_count(bit4), .err_count(err4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Model: strobe k compares rx against the PRBS bit emitted m_delay strobes earlier (0 before start)
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k = 0; m_locked = 1'b0; m_delay = 0; m_wc = 0; m_we = 0;
      m_bit = 0; m_err = 0; m_bit4 = 0; m_err4 = 0;
    end else begin
      if (valid_in) begin
        m_e = int'(rx_in ^ ((k >= m_delay) ? gen[k - m_delay] : 1'b0));
        if (m_locked) begin
          m_bit  = sat(m_bit + 1, 64'hFFFF_FFFF);
          m_err  = sat(m_err + m_e, 64'hFFFF_FFFF);
          m_bit4 = sat(m_bit4 + 1, 15);
          m_err4 = sat(m_err4 + m_e, 15);
        end
        if (m_wc == WIN - 1) begin
          if (!m_locked) begin
            if (m_we + m_e <= 4) begin
              m_locked = 1'b1;
              m_bit = 0; m_err = 0; m_bit4 = 0; m_err4 = 0;
            end else begin
              m_delay = (m_delay + 1) % DMAX;
            end
          end else if (m_we + m_e > 16) begin
            m_locked = 1'b0;
          end
          m_wc = 0;
          m_we = 0;
        end else begin
          m_wc++;
          m_we += m_e;
        end
        k++;
      end
      if (clr) begin
        m_bit = 0; m_err = 0; m_bit4 = 0; m_err4 = 0;
      end
    end
  end

  // Every-cycle compare of both instances against the model
  always @(negedge clk) begin
    chk("locked", longint'(locked), longint'(m_locked));
    chk("delay_out", longint'(delay_out), longint'(m_delay));
    chk("bit_count", longint'(bit_count), m_bit);
    chk("err_count", longint'(err_count), m_err);
    chk("locked4", longint'(locked4), longint'(m_locked));
    chk("delay4", longint'(delay4), longint'(m_delay));
    chk("bit4", longint'(bit4), m_bit4);
    chk("err4", longint'(err4), m_err4);
  end

  task automatic strobe(input bit flip, input int gap);
    valid_in = 1'b1;
    rx_in = ((tx_k >= txd) ? gen[tx_k - txd] : 1'b0) ^ flip;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    clr = 1'b0;
    tx_k++;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int d);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tx_k = 0;
    txd = d;
  endtask

  task automatic chk_lock(input string name, input bit l, input int d);
    chk({name, "_locked"}, longint'(locked), longint'(l));
    chk({name, "_delay"}, longint'(delay_out), longint'(d));
  endtask

  initial begin
    logic [8:0]  l;
    logic [10:0] first_bits;
    int          nb;

    l = 9'h1AA;
    for (int i = 0; i < 4096; i++) begin
      gen[i] = l[8];
      l = {l[7:0], l[8] ^ l[4]};
    end
    first_bits = 11'b11010101010;
    for (int i = 0; i < 11; i++) chk("prbs_head", longint'(gen[i]), longint'(first_bits[10-i]));

    // reset state
    do_reset(5);
    chk_lock("reset", 1'b0, 0);
    chk("reset_bits", longint'(bit_count), 0);
    chk("reset_errs", longint'(err_count), 0);

    // aligned lock, delay 5, strobe every 4 clocks
    for (int i = 0; i < 383; i++) strobe(1'b0, 3);
    chk_lock("pre_lock", 1'b0, 5);
    strobe(1'b0, 3);
    chk_lock("lock5", 1'b1, 5);
    chk("lock5_bits", longint'(bit_count), 0);

    // one flipped bit every 100 strobes
    for (int i = 0; i < 1000; i++) strobe(i % 100 == 99, $urandom_range(0, 2));
    chk("flip_bits", longint'(bit_count), 1000);
    chk("flip_errs", longint'(err_count), 10);
    chk("flip_locked", longint'(locked), 1);
    chk("flip_bit4", longint'(bit4), 15);
    chk("flip_err4", longint'(err4), 10);

    // clr together with a strobe
    clr = 1'b1;
    strobe(1'b0, 1);
    chk("clr_bits", longint'(bit_count), 0);
    chk("clr_errs", longint'(err_count), 0);

    // loss of lock over a fully inverted window
    nb = 0;
    while (tx_k % WIN != 0) begin
      strobe(1'b0, 1);
      nb++;
    end
    for (int i = 0; i < WIN - 1; i++) begin
      strobe(1'b1, 0);
      nb++;
    end
    chk("inv63_locked", longint'(locked), 1);
    chk("inv63_errs", longint'(err_count), 63);
    strobe(1'b1, 0);
    nb++;
    chk_lock("unlock", 1'b0, 5);
    chk("unlock_errs", longint'(err_count), 64);
    chk("unlock_bits", longint'(bit_count), longint'(nb));
    chk("unlock_err4", longint'(err4), 15);
    chk("unlock_bit4", longint'(bit4), 15);
    for (int i = 0; i < WIN; i++) strobe(1'b0, 0);
    chk_lock("relock_same", 1'b1, 5);
    chk("relock_bits", longint'(bit_count), 0);

    // asynchronous reset mid-lock
    for (int i = 0; i < 10; i++) strobe(1'b0, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_lock("async_rst", 1'b0, 0);
    chk("async_rst_bits", longint'(bit_count), 0);
    chk("async_rst_errs", longint'(err_count), 0);
    do_reset(5);
    for (int i = 0; i < 383; i++) strobe(1'b0, $urandom_range(0, 2));
    chk_lock("rst_pre", 1'b0, 5);
    strobe(1'b0, 0);
    chk_lock("rst_relock", 1'b1, 5);

    // largest delay
    do_reset(31);
    for (int i = 0; i < 32 * WIN - 1; i++) strobe(1'b0, 0);
    chk_lock("d31_pre", 1'b0, 31);
    strobe(1'b0, 0);
    chk_lock("d31_lock", 1'b1, 31);

    // out-of-range delay wraps and never locks
    do_reset(40);
    for (int i = 0; i < 31 * WIN; i++) strobe(1'b0, 0);
    chk_lock("d40_31", 1'b0, 31);
    for (int i = 0; i < WIN; i++) strobe(1'b0, 0);
    chk_lock("d40_wrap", 1'b0, 0);
    for (int i = 0; i < WIN; i++) strobe(1'b0, 0);
    chk_lock("d40_next", 1'b0, 1);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
